// File: rtl/mealy_sched_pkg.sv
// Shared definitions for the serial Mealy detector scheduler: state encoding
// and the expected pulse count for a word.
package mealy_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    PREP  = 3'd2,
    SHIFT = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

  // The detector fires on every odd-numbered 1, so the count is ceil(ones/2).
  function automatic int exp_count(input logic [31:0] word, input int width);
    int ones;
    ones = 0;
    for (int i = 0; i < width && i < 32; i++) begin
      ones += int'(word[i]);
    end
    return (ones + 1) / 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first asserted request at or after ptr, wrapping.
// Purely combinational; the pointer register belongs to the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] sel;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      sel = sum[ID_W-1:0];
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/mealy_serial_arbiter.sv
// Shares one serial Mealy detector among N_REQ requesters: grants round-robin,
// shifts the granted word in MSB-first and reports the detector pulse count.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch word/index
// CLR   | detector held in reset for one cycle
// PREP  | detector leaves idle
// SHIFT | WORD_W data bits driven on det_din
// DRAIN | last det_dout sample taken
// DONE  | result strobe with done_id and match_cnt
module mealy_serial_arbiter
  import mealy_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    det_rst,
  output logic                    det_din,
  input  logic                    det_dout,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic [CNT_W-1:0]        match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  bit_q, bit_d, cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0]  gnt_d;
  logic              det_rst_d, det_din_d, done_d;
  logic [ID_W-1:0]   done_id_d;
  logic [CNT_W-1:0]  match_cnt_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic [WORD_W-1:0] words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*WORD_W +: WORD_W];
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Saturating increment guards against a detector that pulses too often.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    word_d      = word_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    det_rst_d   = 1'b0;
    det_din_d   = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id;
    match_cnt_d = match_cnt;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d   = CLR;
          word_d    = words[arb_idx];
          idx_d     = arb_idx;
          gnt_d     = arb_gnt;
          ptr_d     = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d     = '0;
          bit_d     = '0;
          det_rst_d = 1'b1;
        end
      end
      CLR: state_d = PREP;
      PREP: begin
        state_d   = SHIFT;
        det_din_d = word_q[WORD_W-1];
        word_d    = word_q << 1;
      end
      SHIFT: begin
        // det_dout lags det_din by one cycle, so the first SHIFT cycle has nothing to sample.
        if (bit_q != '0 && det_dout) cnt_d = cnt_inc;
        if (bit_q == LAST_BIT) begin
          state_d = DRAIN;
        end else begin
          det_din_d = word_q[WORD_W-1];
          word_d    = word_q << 1;
          bit_d     = bit_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d     = DONE;
        done_d      = 1'b1;
        done_id_d   = idx_q;
        match_cnt_d = det_dout ? cnt_inc : cnt_q;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      det_rst   <= 1'b1;
      det_din   <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      det_rst   <= det_rst_d;
      det_din   <= det_din_d;
      done      <= done_d;
      done_id   <= done_id_d;
      match_cnt <= match_cnt_d;
    end
  end

endmodule

// File: tb/tb_mealy_serial_arbiter.sv
// Bench for mealy_serial_arbiter: behavioural detector, directed vector table,
// multi-cycle corner sequences and randomized rounds against a round-robin model.
module tb_mealy_serial_arbiter;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 8;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    det_rst, det_din, det_dout, done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        match_cnt;

  logic det_armed, det_par, det_q, dout_force;
  int   n_pass = 0;
  int   n_total = 0;
  int   mptr = 0;

  always #5 clk = ~clk;

  mealy_serial_arbiter #(
    .N_REQ(N_REQ), .WORD_W(WORD_W), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .det_rst(det_rst), .det_din(det_din), .det_dout(det_dout),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  // Detector: one idle cycle after reset, then a registered pulse on every odd 1.
  always_ff @(posedge clk) begin
    if (det_rst) begin
      det_armed <= 1'b0;
      det_par   <= 1'b0;
      det_q     <= 1'b0;
    end else if (!det_armed) begin
      det_armed <= 1'b1;
      det_q     <= 1'b0;
    end else begin
      det_q   <= det_din & ~det_par;
      det_par <= det_par ^ det_din;
    end
  end
  assign det_dout = det_q | dout_force;

  typedef struct {
    logic [N_REQ-1:0]  req;
    logic [WORD_W-1:0] data;
    int                id;
    int                cnt;
    bit                spur;
  } vec_t;

  vec_t tv [5];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_word(input int i, input logic [WORD_W-1:0] w);
    req_data[i*WORD_W +: WORD_W] = w;
  endtask

  function automatic int pick(input logic [N_REQ-1:0] mask);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(mptr + k) % N_REQ]) return (mptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic wait_gnt();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
  endtask

  task automatic spur_pulse();
    wait_gnt();
    dout_force = 1'b1;
    repeat (2) @(negedge clk);
    dout_force = 1'b0;
  endtask

  // One full grant: c=0 is the CLR cycle, done expected at c=WORD_W+3.
  task automatic run_txn(input string name, input int exp_id, input logic [WORD_W-1:0] exp_word,
                         input int exp_cnt, input logic [N_REQ-1:0] req_after);
    logic [N_REQ-1:0]  gnt0;
    logic [WORD_W-1:0] stream;
    int rst_cycles, done_c, got_id, got_cnt;
    bit seen, held, rst_first;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1'b1;
    end
    check({name, " grant"}, seen ? int'(gnt) : 0, 1 << exp_id);
    if (!seen) return;
    gnt0 = gnt; stream = '0; rst_cycles = 0; rst_first = det_rst;
    done_c = -1; held = 1'b1; got_id = -1; got_cnt = -1;
    for (int c = 0; c < WORD_W + 8 && done_c < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (gnt !== gnt0) held = 1'b0;
      if (det_rst) rst_cycles++;
      if (c >= 2 && c < WORD_W + 2) stream = {stream[WORD_W-2:0], det_din};
      if (done) begin
        done_c  = c;
        got_id  = int'(done_id);
        got_cnt = int'(match_cnt);
        req     = req_after;
      end
    end
    check({name, " det_rst first"}, int'(rst_first), 1);
    check({name, " det_rst cycles"}, rst_cycles, 1);
    check({name, " din stream"}, int'(stream), int'(exp_word));
    check({name, " latency"}, done_c, WORD_W + 3);
    check({name, " gnt held"}, int'(held), 1);
    check({name, " done_id"}, got_id, exp_id);
    check({name, " match_cnt"}, got_cnt, exp_cnt);
    @(negedge clk);
    check({name, " gnt released"}, int'(gnt), 0);
    check({name, " done one cycle"}, int'(done), 0);
    mptr = (exp_id + 1) % N_REQ;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N_REQ-1:0]  mask, left;
    logic [WORD_W-1:0] w [N_REQ];
    int                e, dones;

    tv[0] = '{4'b0001, 8'hFF, 0, 4, 1'b0};
    tv[1] = '{4'b0010, 8'hF0, 1, 2, 1'b0};
    tv[2] = '{4'b0100, 8'h01, 2, 1, 1'b0};
    tv[3] = '{4'b0100, 8'hE0, 2, 2, 1'b0};
    tv[4] = '{4'b1000, 8'h00, 3, 0, 1'b1};

    rst = 1'b1; req = '0; req_data = '0; dout_force = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("reset gnt", int'(gnt), 0);
    check("reset det_rst", int'(det_rst), 1);
    check("reset det_din", int'(det_din), 0);
    check("reset done", int'(done), 0);
    check("reset done_id", int'(done_id), 0);
    check("reset match_cnt", int'(match_cnt), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle det_rst", int'(det_rst), 0);
    check("idle gnt", int'(gnt), 0);

    for (int i = 0; i < 5; i++) begin
      set_word(tv[i].id, tv[i].data);
      req = tv[i].req;
      fork
        run_txn($sformatf("vec%0d", i), tv[i].id, tv[i].data, tv[i].cnt, '0);
        if (tv[i].spur) spur_pulse();
      join
    end

    // All four pending at once: strict rotation, no fixed priority.
    set_word(0, 8'h11); set_word(1, 8'h77); set_word(2, 8'hFE); set_word(3, 8'h03);
    req = 4'b1111;
    run_txn("simul a", 0, 8'h11, 1, 4'b1111);
    run_txn("simul b", 1, 8'h77, 3, 4'b1111);
    run_txn("simul c", 2, 8'hFE, 4, 4'b1111);
    run_txn("simul d", 3, 8'h03, 1, 4'b1111);
    run_txn("simul e", 0, 8'h11, 1, 4'b0000);

    set_word(2, 8'hA5); req = 4'b0100;
    run_txn("fair serve2", 2, 8'hA5, 2, '0);
    set_word(0, 8'h80); set_word(2, 8'hFF); req = 4'b0101;
    run_txn("fair first", 0, 8'h80, 1, 4'b0100);
    run_txn("fair second", 2, 8'hFF, 4, '0);

    set_word(0, 8'hC3); req = 4'b0001;
    fork
      run_txn("drop", 0, 8'hC3, 2, '0);
      begin
        wait_gnt();
        @(negedge clk);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        set_word(0, 8'hFF);
      end
    join

    set_word(2, 8'h5A); req = 4'b0100;
    wait_gnt();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst gnt", int'(gnt), 0);
    check("midrst det_rst", int'(det_rst), 1);
    check("midrst done", int'(done), 0);
    req = '0; mptr = 0; dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || !det_rst) dones++;
    end
    check("midrst held quiet", dones, 0);
    rst = 1'b1;
    set_word(1, 8'h6D); set_word(3, 8'h81); req = 4'b1010;
    run_txn("post-rst id1", 1, 8'h6D, 3, 4'b1000);
    run_txn("post-rst id3", 3, 8'h81, 1, '0);

    for (int r = 0; r < 20; r++) begin
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int q = 0; q < N_REQ; q++) begin
        w[q] = WORD_W'($urandom);
        set_word(q, w[q]);
      end
      req = mask; left = mask;
      while (left != '0) begin
        e = pick(left);
        left[e] = 1'b0;
        run_txn($sformatf("rand%0d id%0d", r, e), e, w[e],
                mealy_sched_pkg::exp_count(32'(w[e]), WORD_W), left);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
